// File: rtl/stream_packet_arbiter_pkg.sv
// Shared types and helpers for the packet-granular stream arbiter.
package stream_arb_pkg;

  // Upper bound on the source count that the round-robin helper can scan.
  localparam int unsigned ARB_MAX_SRC = 32;
  localparam int unsigned ARB_IDX_W   = 5;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Returns the first requesting index after ptr, wrapping modulo n.
  // If nothing requests, ptr is returned; callers only use the result
  // when at least one request bit is set.
  function automatic int unsigned rr_pick(input logic [ARB_MAX_SRC-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned cand;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 1; i <= ARB_MAX_SRC; i++) begin
      cand = (ptr + i) % n;
      if (!found && (i <= n) && req[cand[ARB_IDX_W-1:0]]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/stream_packet_arbiter_if.sv
// Bundle of the per-source input streams and the merged output stream.
// The master modport is the arbiter side, the slave modport the environment.
interface stream_packet_arbiter_if #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_SRC_COUNT  = 4,
  parameter int T_ID_WIDTH   = (T_SRC_COUNT > 1) ? $clog2(T_SRC_COUNT) : 1
);

  logic [T_DATA_WIDTH-1:0] s_data_i [T_SRC_COUNT];
  logic [T_SRC_COUNT-1:0]  s_last_i;
  logic [T_SRC_COUNT-1:0]  s_valid_i;
  logic [T_SRC_COUNT-1:0]  s_ready_o;
  logic [T_DATA_WIDTH-1:0] m_data_o;
  logic                    m_last_o;
  logic [T_ID_WIDTH-1:0]   m_id_o;
  logic                    m_valid_o;
  logic                    m_ready_i;

  modport master (
    input  s_data_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_id_o, m_valid_o
  );

  modport slave (
    output s_data_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_id_o, m_valid_o
  );

endinterface

// File: rtl/stream_packet_arbiter_rr_arbiter.sv
// Round-robin pointer plus combinational winner selection.
// The pointer remembers the last source that completed a packet, so the
// next scan starts just above it.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int T_SRC_COUNT = 4,
  parameter int T_ID_WIDTH  = (T_SRC_COUNT > 1) ? $clog2(T_SRC_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [T_SRC_COUNT-1:0] req,
  input  logic                   update,
  input  logic [T_ID_WIDTH-1:0]  update_idx,
  output logic [T_ID_WIDTH-1:0]  winner
);

  logic [T_ID_WIDTH-1:0]  ptr;
  logic [ARB_MAX_SRC-1:0] req_ext;

  assign req_ext = ARB_MAX_SRC'(req);
  assign winner  = T_ID_WIDTH'(rr_pick(req_ext, 32'(ptr), T_SRC_COUNT));

  // Pointer starts at the top index so that source 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= T_ID_WIDTH'(T_SRC_COUNT - 1);
    end else if (update) begin
      ptr <= update_idx;
    end
  end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter: holds a grant from the first beat
// of a packet to its last beat and forwards beats through one output register
// tagged with the source index.
module stream_packet_arbiter
  import stream_arb_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_SRC_COUNT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_packet_arbiter_if.master bus
);

  localparam int T_ID_WIDTH = (T_SRC_COUNT > 1) ? $clog2(T_SRC_COUNT) : 1;

  arb_state_t              state_q;
  logic [T_ID_WIDTH-1:0]   grant_q;
  logic [T_ID_WIDTH-1:0]   winner;
  logic [T_SRC_COUNT-1:0]  ready;
  logic                    ready_en;
  logic                    accept;
  logic                    accept_last;
  logic [T_DATA_WIDTH-1:0] data_q;
  logic                    last_q;
  logic [T_ID_WIDTH-1:0]   id_q;
  logic                    valid_q;

  assign ready_en    = (state_q == ARB_BUSY) && (!valid_q || bus.m_ready_i);
  assign accept      = ready_en && bus.s_valid_i[grant_q];
  assign accept_last = accept && bus.s_last_i[grant_q];

  // Only the granted source may see ready, and only when the output slot frees.
  always_comb begin
    ready = '0;
    if (ready_en) begin
      ready[grant_q] = 1'b1;
    end
  end

  stream_rr_arbiter #(
    .T_SRC_COUNT (T_SRC_COUNT),
    .T_ID_WIDTH  (T_ID_WIDTH)
  ) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus.s_valid_i),
    .update     (accept_last),
    .update_idx (grant_q),
    .winner     (winner)
  );

  // Grant FSM: latch a winner in idle, release it after the last beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|bus.s_valid_i) begin
            grant_q <= winner;
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (accept_last) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Output register: load on accept, clear valid once the held beat drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      data_q  <= bus.s_data_i[grant_q];
      last_q  <= bus.s_last_i[grant_q];
      id_q    <= grant_q;
      valid_q <= 1'b1;
    end else if (bus.m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.s_ready_o = ready;
  assign bus.m_data_o  = data_q;
  assign bus.m_last_o  = last_q;
  assign bus.m_id_o    = id_q;
  assign bus.m_valid_o = valid_q;

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Randomized bench for stream_packet_arbiter with a transaction-level model
// of ownership, round-robin order and the single output slot, plus a
// per-source scoreboard of beats taken from each input.
module tb_stream_packet_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  stream_packet_arbiter_if #(.T_DATA_WIDTH(DW), .T_SRC_COUNT(N)) bus ();

  stream_packet_arbiter #(.T_DATA_WIDTH(DW), .T_SRC_COUNT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus state: beats waiting per source, beats taken per source.
  logic [8:0] srcq [N][$];
  logic [8:0] sbq  [N][$];
  int         drop_after [N];
  int         drop_len   [N];
  int         drop_cnt   [N];
  int         vld_pct;
  int         rdy_pct;
  bit         rdy_pattern;
  int         cyc;

  // Observed packet order and currently open output packet.
  int outpkt [$];
  int exp_ids [$];
  int open_id;

  // Reference model: owner of the output path (-1 when none), last finisher,
  // and the one-beat output slot.
  int         owner;
  int         lastw;
  bit         hv;
  logic [7:0] hd;
  bit         hl;
  int         hid;
  logic [N-1:0] exp_rdy;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    owner = -1;
    lastw = N - 1;
    hv    = 1'b0;
    hd    = '0;
    hl    = 1'b0;
    hid   = 0;
  endtask

  task automatic clearQueues();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      sbq[i].delete();
      drop_after[i] = -1;
      drop_len[i]   = 0;
      drop_cnt[i]   = 0;
    end
    outpkt.delete();
    open_id = -1;
  endtask

  task automatic pushPkt(input int src, input logic [7:0] base, input int len);
    for (int k = 0; k < len; k++) begin
      srcq[src].push_back({(k == len - 1), 8'(base + k)});
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.s_valid_i = '0;
    bus.s_last_i  = '0;
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < N; i++) bus.s_data_i[i] = '0;
    #2;
    checkOutput("rst_m_valid", bus.m_valid_o, 0);
    checkOutput("rst_m_data",  bus.m_data_o,  0);
    checkOutput("rst_m_last",  bus.m_last_o,  0);
    checkOutput("rst_m_id",    bus.m_id_o,    0);
    checkOutput("rst_s_ready", bus.s_ready_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearQueues();
    modelReset();
    cyc = 0;
  endtask

  task automatic applyStimulus();
    bit en;
    for (int i = 0; i < N; i++) begin
      en = (srcq[i].size() > 0) && (drop_cnt[i] == 0) && ($urandom_range(99) < vld_pct);
      if (drop_cnt[i] > 0) drop_cnt[i]--;
      bus.s_valid_i[i] = en;
      if (srcq[i].size() > 0) begin
        bus.s_data_i[i] = srcq[i][0][7:0];
        bus.s_last_i[i] = srcq[i][0][8];
      end else begin
        bus.s_data_i[i] = 8'($urandom);
        bus.s_last_i[i] = 1'b0;
      end
    end
    if (rdy_pattern) bus.m_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    else             bus.m_ready_i = ($urandom_range(99) < rdy_pct);
    cyc++;
  endtask

  task automatic modelAdvance();
    bit         acc;
    bit         found;
    int         c;
    logic [8:0] b;
    acc = (owner >= 0) && exp_rdy[owner] && bus.s_valid_i[owner];
    for (int i = 0; i < N; i++) begin
      if (bus.s_valid_i[i] && exp_rdy[i]) begin
        b = srcq[i].pop_front();
        sbq[i].push_back(b);
        if (drop_after[i] > 0) begin
          drop_after[i]--;
          if (drop_after[i] == 0) begin
            drop_cnt[i]   = drop_len[i];
            drop_after[i] = -1;
          end
        end
      end
    end
    if (acc) begin
      hv  = 1'b1;
      hd  = bus.s_data_i[owner];
      hl  = bus.s_last_i[owner];
      hid = owner;
    end else if (hv && bus.m_ready_i) begin
      hv = 1'b0;
    end
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (lastw + k) % N;
        if (!found && bus.s_valid_i[c]) begin
          owner = c;
          found = 1'b1;
        end
      end
    end else if (acc && bus.s_last_i[owner]) begin
      lastw = owner;
      owner = -1;
    end
  endtask

  task automatic step();
    int         id;
    logic [8:0] e;
    applyStimulus();
    @(negedge clk);
    exp_rdy = '0;
    if ((owner >= 0) && (!hv || bus.m_ready_i)) exp_rdy[owner] = 1'b1;
    checkOutput("s_ready", bus.s_ready_o, exp_rdy);
    checkOutput("m_valid", bus.m_valid_o, hv);
    if (hv) begin
      checkOutput("m_data", bus.m_data_o, hd);
      checkOutput("m_last", bus.m_last_o, hl);
      checkOutput("m_id",   bus.m_id_o,   hid);
    end
    if (bus.m_valid_o && bus.m_ready_i) begin
      id = int'(bus.m_id_o);
      if (open_id >= 0) checkOutput("interleave", id, open_id);
      if (sbq[id].size() == 0) begin
        checkOutput("unexpected_beat", 1, 0);
      end else begin
        e = sbq[id].pop_front();
        checkOutput("sb_beat", {bus.m_last_o, bus.m_data_o}, e);
      end
      if (bus.m_last_o) begin
        outpkt.push_back(id);
        open_id = -1;
      end else begin
        open_id = id;
      end
    end
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  task automatic runUntilDone(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      step();
      done = !hv;
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() != 0 || sbq[i].size() != 0) done = 1'b0;
      end
    end
    if (!done) checkOutput("timeout", 1, 0);
  endtask

  task automatic checkOrder(input string tag);
    checkOutput({tag, "_count"}, outpkt.size(), exp_ids.size());
    for (int k = 0; k < exp_ids.size(); k++) begin
      if (k < outpkt.size()) checkOutput({tag, "_id"}, outpkt[k], exp_ids[k]);
    end
  endtask

  initial begin
    vld_pct     = 100;
    rdy_pct     = 100;
    rdy_pattern = 1'b0;
    clearQueues();
    modelReset();
    #1;
    doReset();

    // Single 3-beat packet from source 1.
    pushPkt(1, 8'h11, 3);
    runUntilDone(50);
    exp_ids = '{1};
    checkOrder("single_pkt");

    // All sources streaming 2-beat packets: strict round-robin order.
    doReset();
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < N; s++) pushPkt(s, 8'(8'h20 * s + 8'h2 * p), 2);
    runUntilDone(200);
    exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    checkOrder("rr_all");

    // Granted source 0 stalls mid-packet while source 2 waits.
    doReset();
    pushPkt(0, 8'h40, 4);
    pushPkt(2, 8'h60, 2);
    drop_after[0] = 2;
    drop_len[0]   = 5;
    runUntilDone(100);
    exp_ids = '{0, 2};
    checkOrder("no_preempt");

    // Downstream ready pattern 1,0,0,1 during a 4-beat packet.
    doReset();
    rdy_pattern = 1'b1;
    pushPkt(2, 8'h80, 4);
    runUntilDone(100);
    rdy_pattern = 1'b0;
    exp_ids = '{2};
    checkOrder("backpressure");

    // Reset in the middle of a source-3 packet, then restart from source 0.
    doReset();
    pushPkt(3, 8'h30, 6);
    repeat (4) step();
    checkOutput("pre_reset_valid", bus.m_valid_o, 1);
    doReset();
    pushPkt(0, 8'h50, 2);
    pushPkt(3, 8'h70, 2);
    runUntilDone(100);
    exp_ids = '{0, 3};
    checkOrder("after_reset");

    // Single-beat packets alternating between sources 1 and 2.
    doReset();
    pushPkt(1, 8'hA0, 1);
    pushPkt(1, 8'hA1, 1);
    pushPkt(2, 8'hB0, 1);
    pushPkt(2, 8'hB1, 1);
    runUntilDone(100);
    exp_ids = '{1, 2, 1, 2};
    checkOrder("single_beat");

    // Random traffic with random valid and downstream stalls.
    doReset();
    vld_pct = 60;
    rdy_pct = 70;
    for (int p = 0; p < 40; p++) begin
      pushPkt(int'($urandom_range(N - 1)), 8'($urandom), int'($urandom_range(5, 1)));
    end
    runUntilDone(5000);
    checkOutput("random_pkts", outpkt.size(), 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_packet_arbiter.md
# stream_packet_arbiter

Packet-granular round-robin arbiter that multiplexes T_SRC_COUNT valid/ready/last byte streams onto one output stream. The output feeds a single shared stream_upsize instance. A grant is held from the first beat of a packet through its s_last_i beat, so packets are never interleaved on the shared datapath. The output stage is registered and carries the winning source index for downstream routing.

## Interface
- T_DATA_WIDTH, 8, width of one data beat
- T_SRC_COUNT, 4, number of requesting streams (>=1)
- T_ID_WIDTH, $clog2(T_SRC_COUNT) (min 1), width of the source index; localparam
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- s_data_i  in  T_DATA_WIDTH x T_SRC_COUNT (unpacked array)  per-source data
- s_last_i  in  T_SRC_COUNT  per-source end-of-packet flag
- s_valid_i  in  T_SRC_COUNT  per-source valid
- s_ready_o  out  T_SRC_COUNT  per-source ready; one-hot or zero
- m_data_o  out  T_DATA_WIDTH  forwarded beat
- m_last_o  out  1  forwarded end-of-packet
- m_id_o  out  T_ID_WIDTH  source index of the current beat
- m_valid_o  out  1  output valid
- m_ready_i  in  1  downstream ready, wired to the upsizer's s_ready_o

## Operation
- FSM states: IDLE and BUSY.
- IDLE:
  - If any s_valid_i is set, the winner is the first valid source scanning upward from ptr+1, modulo T_SRC_COUNT.
  - On that edge, grant_q <= winner and the FSM moves to BUSY.
  - With no valid source, the FSM stays in IDLE.
  - s_ready_o = 0 in IDLE.
- BUSY:
  - s_ready_o[grant_q] = !m_valid_o || m_ready_i. All other ready bits are 0.
  - A beat is accepted when s_valid_i[grant_q] && s_ready_o[grant_q].
  - On accept, the output register loads data, last and grant_q into m_id_o, and sets m_valid_o <= 1.
  - If there is no new accept and the held beat drains (m_ready_i=1), m_valid_o <= 0.
- Packet end: when the accepted beat has s_last_i=1, ptr <= grant_q and the FSM returns to IDLE.
- No preemption:
  - If the granted source drops s_valid_i mid-packet, the grant is held indefinitely.
  - Other sources wait.
- s_valid_i on non-granted sources is ignored and never causes data loss, since their ready bits stay 0.
- T_SRC_COUNT=1 degenerates to a registered pass-through with one IDLE cycle between packets.

## Timing
- Reset values:
  - State IDLE; ptr = T_SRC_COUNT-1, so source 0 wins first.
  - grant_q = 0, s_ready_o = 0.
  - m_data_o = 0, m_last_o = 0, m_id_o = 0, m_valid_o = 0.
- Reset asserted mid-packet: all state is cleared immediately, the held output beat is discarded, and the next grant restarts from source 0.
- Latency:
  - The first grant appears on the edge after s_valid_i is seen in IDLE.
  - The first beat is accepted in the following cycle.
  - m_valid_o rises one cycle after accept.
- Throughput: one beat per cycle within a packet while m_ready_i=1.
- Inter-packet gap: exactly one IDLE cycle on the input side after each last beat.
- Backpressure: while m_valid_o && !m_ready_i, m_data_o, m_last_o and m_id_o are held stable.
- A simultaneous drain and accept in the same cycle loads the new beat with no bubble.
- The output handshake is m_valid_o && m_ready_i. Once raised, m_valid_o never drops without a handshake.

## Structure
- Package stream_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t
  - function rr_pick(req, ptr), which returns the winner index with wrap-around.
- Sub-module stream_rr_arbiter holds ptr and computes the winner combinationally:
  - Inputs: clk, rst_n, req, update, update_idx.
  - Output: winner.
  - Top-level contents: the FSM, grant_q, the ready decode and the output register.

## Test plan
- Reset, then src1 sends a 3-beat packet (0x11, 0x12, 0x13 with last on 0x13), m_ready_i=1 -> m_id_o=1, three consecutive m_valid_o beats, m_last_o only on 0x13, no other s_ready_o bit ever set.
- All 4 sources continuously send 2-beat packets -> output packet ids 0,1,2,3,0,1; beats never interleaved; one idle cycle between packets.
- src0 packet in flight, src0 drops valid 5 cycles mid-packet while src2 is valid -> src2 stays un-ready; the src0 packet completes before any src2 beat.
- m_ready_i toggles 1,0,0,1 during a 4-beat packet -> held beat stable while low; no beat lost or duplicated; order preserved.
- rst_n pulsed low mid-packet from src3 -> outputs go to 0 immediately; after release, src0 and src3 both valid -> src0 granted first.
- Single-beat packets (last=1) alternating src1 and src2 -> each grant covers exactly one beat; ids 1,2,1,2.
